// File: rtl/fp_round_unit.sv
// Rounding back end for binary32 results: applies the RISC-V rounding mode to a
// truncated float plus guard/round/sticky bits, over a two-stage valid/ready pipeline.
module fp_round_unit #(
  parameter logic [31:0] CANO_NAN = 32'h7FC00000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] operand_i,
  input  logic [2:0]  grs_i,
  input  logic [2:0]  rm_i,
  input  logic        invalid_i,
  input  logic        divzero_i,
  input  logic        overflow_i,
  input  logic        underflow_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic [4:0]  fflags_o
);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_advance;
  logic in_fire;

  assign s1_advance = !s2_valid_q || ready_i;
  assign ready_o    = !s1_valid_q || s1_advance;
  assign in_fire    = valid_i && ready_o;
  assign valid_o    = s2_valid_q;

  // ---------------------------------------------------------------------------
  // Stage 1: classify the operand and decide the increment
  // ---------------------------------------------------------------------------
  logic       in_sign;
  logic [7:0] in_exp;
  logic       in_lsb;
  logic       in_special;
  logic       in_inexact;
  logic       in_illegal;
  logic       in_inc;

  assign in_sign    = operand_i[31];
  assign in_exp     = operand_i[30:23];
  assign in_lsb     = operand_i[0];
  assign in_special = (in_exp == 8'hFF);
  assign in_inexact = |grs_i;
  assign in_illegal = (rm_i > RM_RMM);

  always_comb begin
    in_inc = 1'b0;
    unique case (rm_i)
      RM_RNE:  in_inc = grs_i[2] && (grs_i[1] || grs_i[0] || in_lsb);
      RM_RTZ:  in_inc = 1'b0;
      RM_RDN:  in_inc = in_sign && in_inexact;
      RM_RUP:  in_inc = !in_sign && in_inexact;
      RM_RMM:  in_inc = grs_i[2];
      default: in_inc = 1'b0;
    endcase
    // Infinities and NaNs are never rounded.
    if (in_special) begin
      in_inc = 1'b0;
    end
  end

  logic [31:0] s1_operand_q, s1_operand_d;
  logic        s1_inc_q, s1_inc_d;
  logic        s1_inexact_q, s1_inexact_d;
  logic        s1_special_q, s1_special_d;
  logic        s1_illegal_q, s1_illegal_d;
  logic [3:0]  s1_flags_q, s1_flags_d;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_operand_d = s1_operand_q;
    s1_inc_d     = s1_inc_q;
    s1_inexact_d = s1_inexact_q;
    s1_special_d = s1_special_q;
    s1_illegal_d = s1_illegal_q;
    s1_flags_d   = s1_flags_q;
    if (in_fire) begin
      s1_valid_d   = 1'b1;
      s1_operand_d = operand_i;
      s1_inc_d     = in_inc;
      s1_inexact_d = in_inexact && !in_special;
      s1_special_d = in_special;
      s1_illegal_d = in_illegal;
      s1_flags_d   = {invalid_i, divzero_i, overflow_i, underflow_i};
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q   <= 1'b0;
      s1_operand_q <= 32'h0;
      s1_inc_q     <= 1'b0;
      s1_inexact_q <= 1'b0;
      s1_special_q <= 1'b0;
      s1_illegal_q <= 1'b0;
      s1_flags_q   <= 4'h0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_operand_q <= s1_operand_d;
      s1_inc_q     <= s1_inc_d;
      s1_inexact_q <= s1_inexact_d;
      s1_special_q <= s1_special_d;
      s1_illegal_q <= s1_illegal_d;
      s1_flags_q   <= s1_flags_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: apply the increment, resolve carry and overflow, build flags
  // ---------------------------------------------------------------------------
  logic        s1_sign;
  logic [7:0]  s1_exp;
  logic [22:0] s1_mant;
  logic [23:0] mant_sum;
  logic        mant_carry;
  logic [7:0]  exp_rnd;
  logic        carry_ovf;
  logic [31:0] rnd_result;
  logic [4:0]  rnd_flags;
  logic        flag_of;

  assign s1_sign    = s1_operand_q[31];
  assign s1_exp     = s1_operand_q[30:23];
  assign s1_mant    = s1_operand_q[22:0];
  assign mant_sum   = {1'b0, s1_mant} + {23'h0, s1_inc_q};
  assign mant_carry = mant_sum[23];
  // Special operands never carry, so exp_rnd cannot wrap past 8'hFF.
  assign exp_rnd    = s1_exp + {7'h0, mant_carry};
  assign carry_ovf  = mant_carry && (exp_rnd == 8'hFF);
  assign flag_of    = s1_flags_q[1] || carry_ovf;

  always_comb begin
    rnd_result = {s1_sign, exp_rnd, mant_sum[22:0]};
    rnd_flags  = 5'h0;
    if (s1_illegal_q) begin
      rnd_result = CANO_NAN;
      rnd_flags  = 5'b10000;
    end else begin
      if (s1_special_q) begin
        rnd_result = s1_operand_q;
      end else if (carry_ovf) begin
        rnd_result = {s1_sign, 8'hFF, 23'h0};
      end
      // Underflow keys off the input exponent so a subnormal that carries into
      // the smallest normal still reports UF when it was inexact.
      rnd_flags[4] = s1_flags_q[3];
      rnd_flags[3] = s1_flags_q[2];
      rnd_flags[2] = flag_of;
      rnd_flags[1] = s1_flags_q[0] || ((s1_exp == 8'h00) && s1_inexact_q);
      rnd_flags[0] = s1_inexact_q || flag_of;
    end
  end

  logic [31:0] result_q, result_d;
  logic [4:0]  fflags_q, fflags_d;

  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    fflags_d   = fflags_q;
    if (s1_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = rnd_result;
        fflags_d = rnd_flags;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      result_q   <= 32'h0;
      fflags_q   <= 5'h0;
    end else begin
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      fflags_q   <= fflags_d;
    end
  end

  assign result_o = result_q;
  assign fflags_o = fflags_q;

endmodule

// File: tb/tb_fp_round_unit.sv
// Directed bench for fp_round_unit: table of rounding vectors plus
// backpressure and mid-flight reset sequences.
module tb_fp_round_unit;

  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] operand_i;
  logic [2:0]  grs_i;
  logic [2:0]  rm_i;
  logic        invalid_i, divzero_i, overflow_i, underflow_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;

  always #5 clk_i = ~clk_i;

  fp_round_unit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .operand_i(operand_i), .grs_i(grs_i), .rm_i(rm_i),
    .invalid_i(invalid_i), .divzero_i(divzero_i),
    .overflow_i(overflow_i), .underflow_i(underflow_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .fflags_o(fflags_o)
  );

  typedef struct {
    logic [31:0] op;
    logic [2:0]  grs;
    logic [2:0]  rm;
    logic [3:0]  fl_in;   // {invalid, divzero, overflow, underflow}
    logic [31:0] res;
    logic [4:0]  ff;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    valid_i   = 1'b1;
    operand_i = v.op;
    grs_i     = v.grs;
    rm_i      = v.rm;
    {invalid_i, divzero_i, overflow_i, underflow_i} = v.fl_in;
  endtask

  // Single transaction with ready_i high; checks result, flags and 2-edge latency.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    bit seen;
    @(negedge clk_i);
    drive(v);
    #1;
    check({tag, " ready_o"}, {31'h0, ready_o}, 32'h1);
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 8) begin
      @(negedge clk_i);
      if (valid_o) seen = 1'b1;
      else begin
        @(posedge clk_i);
        lat++;
      end
    end
    check({tag, " arrived"}, {31'h0, seen}, 32'h1);
    check({tag, " latency"}, lat, 32'd2);
    check({tag, " result"}, result_o, v.res);
    check({tag, " fflags"}, {27'h0, fflags_o}, {27'h0, v.ff});
  endtask

  vec_t bp[4];
  vec_t rv;

  initial begin
    vecs[0]  = '{32'h3F800001, 3'b100, RNE,    4'b0000, 32'h3F800002, 5'b00001};
    vecs[1]  = '{32'h3F800000, 3'b100, RNE,    4'b0000, 32'h3F800000, 5'b00001};
    vecs[2]  = '{32'h3FFFFFFF, 3'b110, RNE,    4'b0000, 32'h40000000, 5'b00001};
    vecs[3]  = '{32'h3FFFFFFF, 3'b110, RTZ,    4'b0000, 32'h3FFFFFFF, 5'b00001};
    vecs[4]  = '{32'h7F7FFFFF, 3'b100, RNE,    4'b0000, 32'h7F800000, 5'b00101};
    vecs[5]  = '{32'hFF7FFFFF, 3'b001, RUP,    4'b0000, 32'hFF7FFFFF, 5'b00001};
    vecs[6]  = '{32'h7FC00001, 3'b000, RNE,    4'b1000, 32'h7FC00001, 5'b10000};
    vecs[7]  = '{32'h3F800000, 3'b101, 3'b111, 4'b0000, 32'h7FC00000, 5'b10000};
    vecs[8]  = '{32'h00000001, 3'b010, RUP,    4'b0000, 32'h00000002, 5'b00011};
    vecs[9]  = '{32'h007FFFFF, 3'b100, RNE,    4'b0000, 32'h00800000, 5'b00011};
    vecs[10] = '{32'hBF800000, 3'b001, RDN,    4'b0000, 32'hBF800001, 5'b00001};
    vecs[11] = '{32'h3F800000, 3'b100, RMM,    4'b0000, 32'h3F800001, 5'b00001};
    vecs[12] = '{32'h3F800000, 3'b111, RDN,    4'b0000, 32'h3F800000, 5'b00001};
    vecs[13] = '{32'h3F800000, 3'b000, RUP,    4'b0000, 32'h3F800000, 5'b00000};
    vecs[14] = '{32'h7F800000, 3'b111, RUP,    4'b0000, 32'h7F800000, 5'b00000};
    vecs[15] = '{32'h7F800000, 3'b000, RNE,    4'b0100, 32'h7F800000, 5'b01000};
    vecs[16] = '{32'h3F800000, 3'b101, RNE,    4'b0000, 32'h3F800001, 5'b00001};
    vecs[17] = '{32'hFF7FFFFF, 3'b001, RDN,    4'b0000, 32'hFF800000, 5'b00101};
    vecs[18] = '{32'h00000004, 3'b000, RTZ,    4'b0001, 32'h00000004, 5'b00010};
    vecs[19] = '{32'h3F800001, 3'b011, RNE,    4'b0000, 32'h3F800001, 5'b00001};
    vecs[20] = '{32'h3F800000, 3'b100, 3'b101, 4'b0000, 32'h7FC00000, 5'b10000};
    vecs[21] = '{32'h3F800000, 3'b011, RMM,    4'b0000, 32'h3F800000, 5'b00001};

    bp[0] = '{32'h3F800001, 3'b100, RNE, 4'b0000, 32'h3F800002, 5'b00001};
    bp[1] = '{32'h3FFFFFFF, 3'b110, RNE, 4'b0000, 32'h40000000, 5'b00001};
    bp[2] = '{32'h40490FDA, 3'b000, RNE, 4'b0000, 32'h40490FDA, 5'b00000};
    bp[3] = '{32'hC0000000, 3'b011, RDN, 4'b0000, 32'hC0000001, 5'b00001};

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    operand_i = 32'h0; grs_i = 3'b0; rm_i = RNE;
    invalid_i = 1'b0; divzero_i = 1'b0; overflow_i = 1'b0; underflow_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("reset valid_o", {31'h0, valid_o}, 32'h0);
    check("reset result_o", result_o, 32'h0);
    check("reset fflags_o", {27'h0, fflags_o}, 32'h0);
    check("reset ready_o", {31'h0, ready_o}, 32'h1);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back stream with ready_i low for cycles 2..5.
    begin
      int sent, got;
      bit stall_seen, holding;
      logic [31:0] held_res;
      logic [4:0]  held_ff;
      sent = 0; got = 0; stall_seen = 1'b0; holding = 1'b0;
      held_res = 32'h0; held_ff = 5'h0;
      for (int c = 0; c < 30 && got < 4; c++) begin
        @(negedge clk_i);
        ready_i = !(c >= 2 && c <= 5);
        if (sent < 4) drive(bp[sent]);
        else valid_i = 1'b0;
        #1;
        if (!ready_o) stall_seen = 1'b1;
        if (holding) begin
          check($sformatf("bp hold valid c%0d", c), {31'h0, valid_o}, 32'h1);
          check($sformatf("bp hold result c%0d", c), result_o, held_res);
          check($sformatf("bp hold fflags c%0d", c), {27'h0, fflags_o}, {27'h0, held_ff});
        end
        if (valid_o && ready_i) begin
          check($sformatf("bp result %0d", got), result_o, bp[got].res);
          check($sformatf("bp fflags %0d", got), {27'h0, fflags_o}, {27'h0, bp[got].ff});
          got++;
          holding = 1'b0;
        end else if (valid_o) begin
          holding  = 1'b1;
          held_res = result_o;
          held_ff  = fflags_o;
        end else begin
          holding = 1'b0;
        end
        if (valid_i && ready_o) sent++;
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      check("bp all results", got, 32'd4);
      check("bp ready_o dropped", {31'h0, stall_seen}, 32'h1);
      repeat (3) begin
        @(negedge clk_i);
        check("bp no duplicate", {31'h0, valid_o}, 32'h0);
      end
    end

    // Fill both stages, then reset for one cycle.
    @(negedge clk_i);
    ready_i = 1'b0;
    drive(bp[0]);
    @(negedge clk_i);
    drive(bp[1]);
    @(negedge clk_i);
    valid_i = 1'b0;
    #1;
    check("rst pre valid_o", {31'h0, valid_o}, 32'h1);
    check("rst pre ready_o", {31'h0, ready_o}, 32'h0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst mid valid_o", {31'h0, valid_o}, 32'h0);
    check("rst mid fflags_o", {27'h0, fflags_o}, 32'h0);
    check("rst mid ready_o", {31'h0, ready_o}, 32'h1);
    ready_i = 1'b1;
    rv = '{32'hBF800000, 3'b001, RDN, 4'b0000, 32'hBF800001, 5'b00001};
    run_vec(rv, "post-reset");
    @(negedge clk_i);
    check("post-reset drained", {31'h0, valid_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
